barrel_shifter_seq_right: RTL

//  Multi-cycle rotate-right barrel shifter: one log2 stage applied per clock, start/done handshake.

---
 rtl/barrel_shifter_seq_right_pkg.sv | 14 +
 rtl/barrel_shifter_seq_right_if.sv | 18 +
 rtl/barrel_shifter_seq_right_stage.sv | 25 ++
 rtl/barrel_shifter_seq_right.sv | 83 ++++++++
 4 files changed

// File: rtl/barrel_shifter_seq_right_pkg.sv
// rtl/barrel_shifter_seq_right_pkg.sv - shared types for the sequential rotate-right shifter
// Purpose: FSM state encoding and default width for barrel_shifter_seq_right.
// Ports:   none (package).
package barrel_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rot_state_t;

endpackage

// File: rtl/barrel_shifter_seq_right_if.sv
// rtl/barrel_shifter_seq_right_if.sv - start/done handshake bundle for the rotate-right shifter
// Purpose: groups request (start, a, amt) and response (ready, done_tick, y) signals.
// Ports:   master drives start/a/amt and observes ready/done_tick/y; slave is the shifter side.
interface barrel_shifter_seq_right_if #(
  parameter int W = barrel_pkg::DEFAULT_W
);
  localparam int N = $clog2(W);

  logic         start;
  logic [W-1:0] a;
  logic [N-1:0] amt;
  logic         ready;
  logic         done_tick;
  logic [W-1:0] y;

  modport master (output start, a, amt, input ready, done_tick, y);
  modport slave  (input start, a, amt, output ready, done_tick, y);
endinterface

// File: rtl/barrel_shifter_seq_right_stage.sv
// rtl/barrel_shifter_seq_right_stage.sv - one combinational log2 rotate-right stage
// Purpose: q = d rotated right by 2**sel when en, else d.
// Ports:   d (W) data in, sel (N) stage index, en stage enable, q (W) result.
module rotate_right_stage #(
  parameter  int W = 8,
  localparam int N = $clog2(W)
) (
  input  logic [W-1:0] d,
  input  logic [N-1:0] sel,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [N-1:0] sh;
  logic [W-1:0] rot;

  // sel <= N-1, so 2**sel <= W/2 always fits in N bits.
  // Shifting the doubled word right and keeping the low half is a lossless rotate.
  always_comb begin
    sh  = N'(1) << sel;
    rot = W'({d, d} >> sh);
    q   = en ? rot : d;
  end

endmodule

// File: rtl/barrel_shifter_seq_right.sv
// rtl/barrel_shifter_seq_right.sv - multi-cycle rotate-right barrel shifter, one stage per clock
// Purpose: rotates a right by amt over N clocks (fixed latency), start/done handshake.
// Ports:   clk rising-edge clock; reset async active-high;
//          bus (slave): start, a, amt in; ready, done_tick, y out.
module barrel_shifter_seq_right
  import barrel_pkg::*;
#(
  parameter  int W = 8,
  localparam int N = $clog2(W)
) (
  input  logic                           clk,
  input  logic                           reset,
  barrel_shifter_seq_right_if.slave      bus
);

  rot_state_t   state, state_nxt;
  logic [W-1:0] data_reg;
  logic [N-1:0] amt_reg;
  logic [N-1:0] stage;
  logic [W-1:0] y_reg;
  logic [W-1:0] stage_out;
  logic         last_stage;

  // A single stage is time-shared; the stage counter picks the rotate distance.
  rotate_right_stage #(.W(W)) u_stage (
    .d   (data_reg),
    .sel (stage),
    .en  (amt_reg[stage]),
    .q   (stage_out)
  );

  assign last_stage    = (stage == N'(N - 1));
  assign bus.ready     = (state == IDLE);
  assign bus.done_tick = (state == DONE);
  assign bus.y         = y_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_stage) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // No early exit on amt==0: every op walks all N stages so latency is data-independent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      amt_reg  <= '0;
      stage    <= '0;
      y_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            data_reg <= bus.a;
            amt_reg  <= bus.amt;
            stage    <= '0;
          end
        end
        SHIFT: begin
          data_reg <= stage_out;
          if (last_stage) begin
            y_reg <= stage_out;
            // Park at 0 so amt_reg[stage] never indexes past N-1.
            stage <= '0;
          end else begin
            stage <= stage + N'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
